// File: rtl/idct_8x8_serial.sv
// idct_8x8_serial: serial 8x8 inverse DCT, one multiply-accumulate per cycle.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_coef carry the
// coefficient stream X[k1][k2] in row-major order; out_valid/out_ready/out_pixel
// carry the pixel stream x[n1][n2] in row-major order; busy is high outside
// LOAD; block_done pulses once after the last pixel is accepted.
// Optional macro IDCT_LEVEL_SHIFT_EN: add 128 and clamp pixels to unsigned 8-bit.
module idct_8x8_serial #(
  parameter int COEF_W = 16,
  parameter int PIX_W = 9,
  parameter int ACC_W = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic out_valid,
  input  logic out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic busy,
  output logic block_done
);
  typedef enum logic [1:0] {LOAD, MAC, ROUND, EMIT} state_t;
  localparam logic signed [11:0] CTAB [16] = '{
    12'sd512, 12'sd502, 12'sd473, 12'sd426, 12'sd362, 12'sd284, 12'sd196, 12'sd100,
    12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< 19;
  state_t state, state_nx;
  logic [5:0] i_cnt, m_cnt, j_cnt;
  logic signed [COEF_W-1:0] coef_mem [64];
  logic signed [ACC_W-1:0] acc, rnd;
  logic signed [11:0] c1, c2;
  logic signed [COEF_W+23:0] prod;
  logic [PIX_W-1:0] pix_nx;
  logic in_fire, out_fire;
  // 512*cos(a*pi/16) folded to the first quadrant; a(0) row is the constant 362.
  function automatic logic signed [11:0] cos_rom(input logic [2:0] k, input logic [2:0] n);
    logic [7:0] p;
    logic [4:0] f;
    logic [3:0] g;
    p = {4'b0, n, 1'b1} * {5'b0, k};
    f = p[4] ? 5'd0 - p[4:0] : p[4:0];
    g = f > 5'd8 ? 4'(5'd16 - f) : f[3:0];
    return k == 3'd0 ? 12'sd362 : (f > 5'd8 ? -CTAB[g] : CTAB[g]);
  endfunction
  assign in_ready = state == LOAD;
  assign busy = state != LOAD;
  assign out_valid = state == EMIT;
  assign in_fire = in_ready && in_valid;
  assign out_fire = out_valid && out_ready;
  assign c1 = cos_rom(m_cnt[5:3], j_cnt[5:3]);
  assign c2 = cos_rom(m_cnt[2:0], j_cnt[2:0]);
  assign prod = coef_mem[m_cnt] * c1 * c2;
  assign rnd = (acc + HALF) >>> 20;
`ifdef IDCT_LEVEL_SHIFT_EN
  logic signed [ACC_W-1:0] sh;
  assign sh = rnd + 128;
  assign pix_nx = sh > 255 ? PIX_W'(255) : sh < 0 ? '0 : PIX_W'(sh[7:0]);
`else
  localparam logic signed [ACC_W-1:0] PMAX = (ACC_W'(1) <<< (PIX_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] PMIN = -(ACC_W'(1) <<< (PIX_W - 1));
  assign pix_nx = rnd > PMAX ? PMAX[PIX_W-1:0] : rnd < PMIN ? PMIN[PIX_W-1:0] : rnd[PIX_W-1:0];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == LOAD ? (in_fire && i_cnt == 6'd63 ? MAC : LOAD) :
               state == MAC ? (m_cnt == 6'd63 ? ROUND : MAC) :
               state == ROUND ? EMIT :
               (out_fire ? (j_cnt == 6'd63 ? LOAD : MAC) : EMIT);
  end
  always_ff @(posedge clk)
    if (in_fire) coef_mem[i_cnt] <= in_coef;
  // Counters wrap naturally at 64, so each returns to 0 for the next pass.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i_cnt <= '0;
      m_cnt <= '0;
      j_cnt <= '0;
      acc <= '0;
      out_pixel <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= out_fire && j_cnt == 6'd63;
      if (in_fire) i_cnt <= i_cnt + 6'd1;
      if (state == MAC) m_cnt <= m_cnt + 6'd1;
      if (out_fire) j_cnt <= j_cnt + 6'd1;
      if (state == ROUND) out_pixel <= pix_nx;
      acc <= state == MAC ? acc + ACC_W'(prod) : (state_nx == MAC ? '0 : acc);
    end
endmodule

// File: tb/tb_idct_8x8_serial.sv
// tb_idct_8x8_serial: randomized self-checking bench against a floating-point-derived IDCT model.
module tb_idct_8x8_serial;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [15:0] in_coef = '0;
  logic in_ready, out_valid, busy, block_done;
  logic [8:0] out_pixel;
  int checks = 0, errors = 0;
  int x [64];
  int cr [8][8];
  longint got [64];
  always #5 clk = ~clk;
  idct_8x8_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .busy(busy), .block_done(block_done));
  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic longint ref_pix(input int j);
    longint s = 0, r;
    for (int k1 = 0; k1 < 8; k1++)
      for (int k2 = 0; k2 < 8; k2++)
        s += longint'(x[k1*8+k2]) * cr[k1][j/8] * cr[k2][j%8];
    r = (s + (longint'(1) << 19)) >>> 20;
`ifdef IDCT_LEVEL_SHIFT_EN
    r += 128;
    return r > 255 ? 255 : r < 0 ? 0 : r;
`else
    return r > 255 ? 255 : r < -256 ? -256 : r;
`endif
  endfunction
  task automatic send_block();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(3) == 0) begin
        in_valid = 0;
        @(negedge clk);
      end
      in_valid = 1;
      in_coef = 16'(x[i]);
      @(negedge clk);
    end
    in_valid = 0;
    check("in_ready_low", in_ready, 0);
    check("busy_mac", busy, 1);
  endtask
  task automatic recv_block(input int bp_j, input int rst_j);
    int cnt, hold;
    longint held;
    for (int j = 0; j < 64; j++) begin
      cnt = 0;
      while (!out_valid && cnt < 100) begin
        @(negedge clk);
        cnt++;
        in_valid = 1'($urandom_range(1));
        in_coef = 16'($urandom);
        if (j == rst_j && cnt == 30) begin
          rst = 1;
          #1;
          check("rst_out_valid", out_valid, 0);
          check("rst_in_ready", in_ready, 1);
          check("rst_busy", busy, 0);
          check("rst_out_pixel", out_pixel, 0);
          @(negedge clk);
          rst = 0;
          in_valid = 0;
          return;
        end
      end
      check($sformatf("latency%0d", j), cnt, 65);
      if (!out_valid) begin
        in_valid = 0;
        return;
      end
      got[j] = $signed(out_pixel);
      check($sformatf("pix%0d", j), got[j], ref_pix(j));
      held = got[j];
      hold = j == bp_j ? 10 : $urandom_range(2);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_pixel", $signed(out_pixel), held);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      in_valid = 0;
      check($sformatf("done%0d", j), block_done, j == 63);
    end
    check("in_ready_back", in_ready, 1);
    check("busy_idle", busy, 0);
    @(negedge clk);
    check("done_pulse_end", block_done, 0);
  endtask
  task automatic set_one(input int idx, input int v);
    for (int i = 0; i < 64; i++) x[i] = 0;
    x[idx] = v;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        cr[k][n] = int'($floor((k == 0 ? $sqrt(1.0 / 8.0) : 0.5) *
                               $cos((2 * n + 1) * k * 3.14159265358979 / 16.0) * 1024.0 + 0.5));
    check("rom_c00", cr[0][3], 362);
    check("rom_c10", cr[1][0], 502);
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", block_done, 0);
    check("reset_pixel", out_pixel, 0);
    rst = 0;
    @(negedge clk);
    set_one(0, 1024);
    send_block();
    recv_block(5, -1);
`ifndef IDCT_LEVEL_SHIFT_EN
    check("dc_pix0", got[0], 128);
    check("dc_pix63", got[63], 128);
`endif
    set_one(0, 0);
    send_block();
    recv_block(-1, -1);
    set_one(0, -4096);
    send_block();
    recv_block(-1, -1);
    set_one(0, -2048);
    send_block();
    recv_block(-1, -1);
    set_one(1, 1024);
    send_block();
    recv_block(-1, -1);
`ifndef IDCT_LEVEL_SHIFT_EN
    check("x01_pix0", got[0], 177);
    check("x01_pix7", got[7], -177);
    check("x01_pix56", got[56], 177);
`endif
    set_one(0, 1024);
    send_block();
    recv_block(-1, 20);
    @(negedge clk);
    send_block();
    recv_block(-1, -1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) x[i] = int'($urandom_range(600)) - 300;
      x[0] = int'($urandom_range(4095)) - 2048;
      send_block();
      recv_block(int'($urandom_range(63)), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
